// File: rtl/fpunit_pkg.sv
// Shared definitions for the fpunit divide path.
// Contents: IDIV opcode constant, default lane geometry and divide latency,
// and the issue/writeback sequencer state encoding.
package fpunit_pkg;

  localparam logic [5:0] OP_IDIV = 6'h38;

  localparam int N_DEF            = 32;
  localparam int L_DEF            = 4;
  localparam int LATENCY_IDIV_DEF = 32;
  localparam int TAG_W_DEF        = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } div_state_e;

endpackage

// File: rtl/alu_div_issue.sv
// alu_div_issue: initiator side of the multi-cycle integer divide unit.
// Accepts one IDIV request (valid/ready), holds operands and div_ivalid while
// the unit runs, captures q/r into a single result slot on div_finish, and
// back-pressures the unit with div_stall while the slot cannot take a result.
// Illegal opcodes bypass the unit and load the slot with an error response.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req_valid/req_ready              request handshake
//   req_op, req_tag, req_a, req_b    request opcode, tag, dividends, divisors
//   div_ivalid, div_stall            to unit: operation active, hold finish
//   div_a, div_b                     to unit: operands
//   div_q, div_r, div_finish         from unit: results and result-ready
//   rsp_valid/rsp_ready              result slot handshake
//   rsp_q, rsp_r, rsp_tag, rsp_err   result slot contents
//
// Build option: define DIV_TIMEOUT_EN to add a watchdog that answers with
// rsp_err=1 if the unit has not finished LATENCY_IDIV+4 unstalled cycles
// after issue.
//
// state | meaning
// IDLE  | ready for a request; illegal ops answered directly into the slot
// BUSY  | div_ivalid high, operands held, waiting for div_finish
// GAP   | one cycle with div_ivalid low so the unit's counter clears
module alu_div_issue
  import fpunit_pkg::*;
#(
  parameter int N            = N_DEF,
  parameter int L            = L_DEF,
  parameter int LATENCY_IDIV = LATENCY_IDIV_DEF,
  parameter int TAG_W        = TAG_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [5:0]         req_op,
  input  logic [TAG_W-1:0]   req_tag,
  input  logic [N*L-1:0]     req_a,
  input  logic [N*L-1:0]     req_b,
  output logic               div_ivalid,
  output logic               div_stall,
  output logic [N*L-1:0]     div_a,
  output logic [N*L-1:0]     div_b,
  input  logic [N*L-1:0]     div_q,
  input  logic [N*L-1:0]     div_r,
  input  logic               div_finish,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [N*L-1:0]     rsp_q,
  output logic [N*L-1:0]     rsp_r,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic               rsp_err
);

  if (LATENCY_IDIV < 1) begin : g_bad_latency
    $error("alu_div_issue: LATENCY_IDIV must be at least 1");
  end

  div_state_e       state;
  logic [TAG_W-1:0] tag_q;
  logic             legal;
  logic             take;
  logic             capture;
  logic             wd_fire;

  assign legal = (req_op == OP_IDIV);

  // An illegal op needs a free slot right now; a legal op can be accepted
  // with the slot full because the stall path protects the capture later.
  // Only registered slot state is used, never rsp_ready.
  assign req_ready = (state == ST_IDLE) && !rst && (legal || !rsp_valid);
  assign take      = req_valid && req_ready;

  assign div_stall = (state == ST_BUSY) && rsp_valid && !rsp_ready;
  assign capture   = (state == ST_BUSY) && div_finish && !div_stall;

`ifdef DIV_TIMEOUT_EN
  localparam int WD_W = $clog2(LATENCY_IDIV + 4);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(LATENCY_IDIV + 3);

  logic [WD_W-1:0] wdog;

  // Down-counter loaded on issue; terminal count fires on the
  // (LATENCY_IDIV+4)th unstalled BUSY cycle. A real finish wins a tie.
  assign wd_fire = (state == ST_BUSY) && !div_stall && !div_finish && (wdog == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog <= '0;
    end else if (take && legal) begin
      wdog <= WD_LOAD;
    end else if ((state == ST_BUSY) && !div_stall && (wdog != '0)) begin
      wdog <= wdog - 1'b1;
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      div_ivalid <= 1'b0;
      div_a      <= '0;
      div_b      <= '0;
      tag_q      <= '0;
      rsp_valid  <= 1'b0;
      rsp_q      <= '0;
      rsp_r      <= '0;
      rsp_tag    <= '0;
      rsp_err    <= 1'b0;
    end else begin
      // Drain first; a load later in this block refills the slot.
      if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (take) begin
            if (legal) begin
              div_a      <= req_a;
              div_b      <= req_b;
              tag_q      <= req_tag;
              div_ivalid <= 1'b1;
              state      <= ST_BUSY;
            end else begin
              rsp_valid <= 1'b1;
              rsp_q     <= '0;
              rsp_r     <= '0;
              rsp_tag   <= req_tag;
              rsp_err   <= 1'b1;
            end
          end
        end

        ST_BUSY: begin
          if (capture) begin
            rsp_valid  <= 1'b1;
            rsp_q      <= div_q;
            rsp_r      <= div_r;
            rsp_tag    <= tag_q;
            rsp_err    <= 1'b0;
            div_ivalid <= 1'b0;
            state      <= ST_GAP;
          end else if (wd_fire) begin
            rsp_valid  <= 1'b1;
            rsp_q      <= '0;
            rsp_r      <= '0;
            rsp_tag    <= tag_q;
            rsp_err    <= 1'b1;
            div_ivalid <= 1'b0;
            state      <= ST_GAP;
          end
        end

        ST_GAP: begin
          state <= ST_IDLE;
        end

        default: begin
          state      <= ST_IDLE;
          div_ivalid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_issue.sv
module tb_alu_div_issue;

  localparam int N     = 32;
  localparam int L     = 4;
  localparam int LAT   = 32;
  localparam int TAG_W = 5;
  localparam int W     = N * L;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [5:0]       req_op;
  logic [TAG_W-1:0] req_tag;
  logic [W-1:0]     req_a;
  logic [W-1:0]     req_b;
  logic             div_ivalid;
  logic             div_stall;
  logic [W-1:0]     div_a;
  logic [W-1:0]     div_b;
  logic [W-1:0]     div_q;
  logic [W-1:0]     div_r;
  logic             div_finish;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_q;
  logic [W-1:0]     rsp_r;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_div_issue #(.N(N), .L(L), .LATENCY_IDIV(LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_tag(req_tag), .req_a(req_a), .req_b(req_b),
    .div_ivalid(div_ivalid), .div_stall(div_stall),
    .div_a(div_a), .div_b(div_b),
    .div_q(div_q), .div_r(div_r), .div_finish(div_finish),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
  );

  // Divide unit model: counts ivalid-high edges, finishes at LAT and holds
  // finish until ivalid drops. model_dead emulates a hung unit.
  int unsigned mcnt = 0;
  logic model_dead = 1'b0;

  always @(posedge clk) begin
    if (!div_ivalid) mcnt <= 0;
    else if (mcnt < LAT) mcnt <= mcnt + 1;
  end

  assign div_finish = div_ivalid && !model_dead && (mcnt == LAT);

  always_comb begin
    div_q = '0;
    div_r = '0;
    for (int i = 0; i < L; i++) begin
      if (div_b[N*i +: N] != '0) begin
        div_q[N*i +: N] = div_a[N*i +: N] / div_b[N*i +: N];
        div_r[N*i +: N] = div_a[N*i +: N] % div_b[N*i +: N];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(input int limit, output int n);
    n = 0;
    while (!rsp_valid && n < limit) begin
      step();
      n++;
    end
  endtask

  int n;
  int seen;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 6'h0; req_tag = '0;
    req_a = '0; req_b = '0; rsp_ready = 1'b1;
    step(); step();

    // Reset values, sampled while rst is still high
    check("rst_req_ready", req_ready, 0);
    check("rst_ivalid",    div_ivalid, 0);
    check("rst_stall",     div_stall, 0);
    check("rst_div_a",     div_a, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_q",     rsp_q, 0);
    check("rst_rsp_tag",   rsp_tag, 0);
    check("rst_rsp_err",   rsp_err, 0);

    rst = 1'b0;
    step();
    check("idle_req_ready", req_ready, 1);

    // Basic divide: 100/7 in every lane, tag 3
    req_valid = 1'b1; req_op = 6'h38; req_tag = 5'd3;
    req_a = {4{32'd100}}; req_b = {4{32'd7}};
    step();
    req_valid = 1'b0;
    check("t1_ivalid",    div_ivalid, 1);
    check("t1_div_a",     div_a, {4{32'd100}});
    check("t1_ready_low", req_ready, 0);
    wait_rsp(100, n);
    check("t1_latency", n, 33);
    check("t1_q",   rsp_q, {4{32'd14}});
    check("t1_r",   rsp_r, {4{32'd2}});
    check("t1_tag", rsp_tag, 3);
    check("t1_err", rsp_err, 0);
    check("t1_gap_ivalid", div_ivalid, 0);
    check("t1_gap_ready",  req_ready, 0);
    step();
    check("t1_drained", rsp_valid, 0);
    check("t1_idle_ready", req_ready, 1);

    // Illegal op with writeback stalled: error response lands in the slot
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_op = 6'h10; req_tag = 5'd7;
    req_a = {4{32'd55}}; req_b = {4{32'd5}};
    step();
    check("ill_ivalid", div_ivalid, 0);
    check("ill_valid",  rsp_valid, 1);
    check("ill_err",    rsp_err, 1);
    check("ill_q",      rsp_q, 0);
    check("ill_r",      rsp_r, 0);
    check("ill_tag",    rsp_tag, 7);
    check("ill_ready_full", req_ready, 0);

    // Legal op still accepted with slot full; finish then stalls
    req_op = 6'h38; req_tag = 5'd5;
    req_a = {4{32'd200}}; req_b = {4{32'd9}};
    #1;
    check("st_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    n = 0;
    while (!div_finish && n < 100) begin
      step();
      n++;
    end
    check("st_finish_seen", div_finish, 1);
    check("st_stall", div_stall, 1);
    repeat (5) step();
    check("st_stall_hold", div_stall, 1);
    check("st_slot_tag_hold", rsp_tag, 7);
    check("st_slot_err_hold", rsp_err, 1);
    check("st_ivalid_hold", div_ivalid, 1);
    rsp_ready = 1'b1;
    #1;
    check("st_stall_release", div_stall, 0);
    step();
    check("st_cap_valid", rsp_valid, 1);
    check("st_cap_q",   rsp_q, {4{32'd22}});
    check("st_cap_r",   rsp_r, {4{32'd2}});
    check("st_cap_tag", rsp_tag, 5);
    check("st_cap_err", rsp_err, 0);
    check("st_gap_ivalid", div_ivalid, 0);
    check("st_gap_ready",  req_ready, 0);
    step();
    check("st_after_gap_ivalid", div_ivalid, 0);
    check("st_after_gap_ready",  req_ready, 1);

    // Back-to-back requests with distinct lanes
    req_valid = 1'b1; req_op = 6'h38; req_tag = 5'd9;
    req_a = {32'd1000, 32'd81, 32'd17, 32'd5};
    req_b = {32'd10,   32'd9,  32'd4,  32'd3};
    step();
    req_tag = 5'd10;
    req_a = {4{32'hFFFF_FFFF}}; req_b = {4{32'd16}};
    check("bb_ready_busy", req_ready, 0);
    wait_rsp(100, n);
    check("bb1_latency", n, 33);
    check("bb1_q",   rsp_q, {32'd100, 32'd9, 32'd4, 32'd1});
    check("bb1_r",   rsp_r, {32'd0,   32'd0, 32'd1, 32'd2});
    check("bb1_tag", rsp_tag, 9);
    check("bb_ready_gap", req_ready, 0);
    step();
    check("bb_ready_after_gap", req_ready, 1);
    step();
    req_valid = 1'b0;
    check("bb2_ivalid", div_ivalid, 1);
    wait_rsp(100, n);
    check("bb2_latency", n, 33);
    check("bb2_q",   rsp_q, {4{32'h0FFF_FFFF}});
    check("bb2_r",   rsp_r, {4{32'd15}});
    check("bb2_tag", rsp_tag, 10);
    step(); step();

    // Reset in the middle of an operation
    req_valid = 1'b1; req_op = 6'h38; req_tag = 5'd12;
    req_a = {4{32'd50}}; req_b = {4{32'd5}};
    step();
    req_valid = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    step();
    check("mr_req_ready", req_ready, 0);
    check("mr_ivalid",    div_ivalid, 0);
    check("mr_div_a",     div_a, 0);
    check("mr_rsp_valid", rsp_valid, 0);
    check("mr_rsp_tag",   rsp_tag, 0);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      step();
      if (rsp_valid) seen++;
    end
    check("mr_no_rsp", seen, 0);
    check("mr_idle_ready", req_ready, 1);

    // Hung unit
    model_dead = 1'b1;
    req_valid = 1'b1; req_op = 6'h38; req_tag = 5'd17;
    req_a = {4{32'd9}}; req_b = {4{32'd3}};
    step();
    req_valid = 1'b0;
`ifdef DIV_TIMEOUT_EN
    wait_rsp(60, n);
    check("to_latency", n, 36);
    check("to_err",  rsp_err, 1);
    check("to_q",    rsp_q, 0);
    check("to_r",    rsp_r, 0);
    check("to_tag",  rsp_tag, 17);
    check("to_ivalid", div_ivalid, 0);
    step();
    model_dead = 1'b0;
    check("to_idle_ready", req_ready, 1);
`else
    seen = 0;
    repeat (60) begin
      step();
      if (rsp_valid) seen++;
    end
    check("hang_no_rsp", seen, 0);
    check("hang_ivalid", div_ivalid, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
